// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file widths and the write-queue entry record.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_COUNT      = 32;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } wq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wq_bypass_match.sv
`default_nettype none
// ============================================================================
// Module   : wq_bypass_match
// Brief    : Newest-match search over the write-queue entries for one lookup.
// Revision : 1.0 - initial release
// ============================================================================
module wq_bypass_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wq_entry_t [DEPTH-1:0]       entries,
    input  logic [DEPTH-1:0]            valid,
    input  logic [PTR_W-1:0]            head,
    input  logic [REG_ADDR_WIDTH-1:0]   lookup,
    output logic                        hit,
    output logic [REG_DATA_WIDTH-1:0]   data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].addr == lookup)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_queue
// Brief    : In-order queue merging mem/ALU register writes onto one RF port.
//            Optional bypass lookup enabled by macro REGFILE_WQ_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memValid,
    input  logic [ADDR_WIDTH-1:0]   memRegister,
    input  logic [DATA_WIDTH-1:0]   memData,
    output logic                    memReady,
    input  logic                    aluValid,
    input  logic [ADDR_WIDTH-1:0]   aluRegister,
    input  logic [DATA_WIDTH-1:0]   aluData,
    output logic                    aluReady,
    output logic [ADDR_WIDTH-1:0]   writeRegister,
    output logic [DATA_WIDTH-1:0]   writeData,
    output logic                    regWrite,
    input  logic [ADDR_WIDTH-1:0]   lookupRegister1,
    input  logic [ADDR_WIDTH-1:0]   lookupRegister2,
    output logic                    lookupHit1,
    output logic                    lookupHit2,
    output logic [DATA_WIDTH-1:0]   lookupData1,
    output logic [DATA_WIDTH-1:0]   lookupData2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      alu_slot;
    logic [CNT_W-1:0]      free;
    logic [CNT_W-1:0]      count_next;
    logic                  push_mem;
    logic                  push_alu;
    logic                  pop;

    // Readiness looks only at the registered count, so the same-cycle pop never helps.
    assign free     = CNT_W'(DEPTH) - count;
    assign memReady = reset || (free >= CNT_W'(1));
    assign aluReady = reset || (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !memValid);

    assign push_mem   = memValid && memReady && !reset;
    assign push_alu   = aluValid && aluReady && !reset;
    assign pop        = (count != '0);
    assign alu_slot   = tail + PTR_W'(push_mem);
    assign count_next = count + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push_mem) entries[tail]     <= '{addr: memRegister, data: memData};
        if (push_alu) entries[alu_slot] <= '{addr: aluRegister, data: aluData};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
        end else begin
            tail  <= tail + PTR_W'(push_mem) + PTR_W'(push_alu);
            count <= count_next;
            if (pop) begin
                head          <= head + PTR_W'(1);
                regWrite      <= 1'b1;
                writeRegister <= entries[head].addr;
                writeData     <= entries[head].data;
            end else begin
                regWrite      <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WQ_BYPASS_EN
    logic [DEPTH-1:0]      valid;
    logic                  q_hit1;
    logic                  q_hit2;
    logic [DATA_WIDTH-1:0] q_data1;
    logic [DATA_WIDTH-1:0] q_data2;
    logic                  out_hit1;
    logic                  out_hit2;

    for (genvar k = 0; k < DEPTH; k++) begin : g_valid
        logic [PTR_W-1:0] age;
        assign age      = PTR_W'(k) - head;
        assign valid[k] = ({1'b0, age} < count);
    end

    wq_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .lookup  (lookupRegister1),
        .hit     (q_hit1),
        .data    (q_data1)
    );

    wq_bypass_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .lookup  (lookupRegister2),
        .hit     (q_hit2),
        .data    (q_data2)
    );

    // The output register is the oldest pending write; queue matches take priority.
    assign out_hit1    = regWrite && (writeRegister == lookupRegister1);
    assign out_hit2    = regWrite && (writeRegister == lookupRegister2);
    assign lookupHit1  = q_hit1 || out_hit1;
    assign lookupHit2  = q_hit2 || out_hit2;
    assign lookupData1 = q_hit1 ? q_data1 : (out_hit1 ? writeData : '0);
    assign lookupData2 = q_hit2 ? q_data2 : (out_hit2 ? writeData : '0);
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookupRegister1, lookupRegister2};
    assign lookupHit1    = 1'b0;
    assign lookupHit2    = 1'b0;
    assign lookupData1   = '0;
    assign lookupData2   = '0;
`endif

endmodule
`default_nettype wire
